// File: rtl/dispatch_queue_if.sv
// Bus bundle between decode, the dispatch queue and the reservation stations.
// master = decode/ROB/station side, slave = the queue itself.
interface dispatch_queue_if #(
    parameter int UOP = 95,
    parameter int RS  = 1,
    parameter int ROB = 2
);
    localparam int NUM_RS = 2 ** (RS + 1);

    logic              inValid;
    logic [UOP:0]      inUop;
    logic [RS:0]       inStation;
    logic              inReady;
    logic              freeze;
    logic [NUM_RS-1:0] rsFull;
    logic              commitValid;
    logic              flush;
    logic [1:0]        dispValid;
    logic [UOP:0]      dispUop0;
    logic [UOP:0]      dispUop1;
    logic [RS:0]       dispStation0;
    logic [RS:0]       dispStation1;
    logic [ROB:0]      dispRob0;
    logic [ROB:0]      dispRob1;
    logic [ROB+1:0]    robFreeCount;

    modport master (
        output inValid, inUop, inStation, rsFull, commitValid, flush,
        input  inReady, freeze, dispValid, dispUop0, dispUop1, dispStation0,
               dispStation1, dispRob0, dispRob1, robFreeCount
    );

    modport slave (
        input  inValid, inUop, inStation, rsFull, commitValid, flush,
        output inReady, freeze, dispValid, dispUop0, dispUop1, dispStation0,
               dispStation1, dispRob0, dispRob1, robFreeCount
    );
endinterface

// File: rtl/dispatch_queue.sv
// In-order decode-to-station queue: buffers micro-ops, dispatches up to two per
// cycle with wrap-around ROB tag allocation, single-cycle flush.
module dispatch_queue #(
    parameter int UOP   = 95,
    parameter int DEPTH = 4,
    parameter int RS    = 1,
    parameter int ROB   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    dispatch_queue_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = ROB + 1;
    localparam int UW = ROB + 2;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [UW-1:0] ROB_N_C   = UW'(2 ** (ROB + 1));
    localparam logic [UW-1:0] ROB_N2_C  = UW'(2 ** (ROB + 1) - 2);

    logic [UOP:0]    r_uop [DEPTH];
    logic [RS:0]     r_stn [DEPTH];
    logic [AW-1:0]   r_head, r_tail;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_robTail, r_robHead;
    logic [UW-1:0]   r_robUsed, r_robFree;
    logic [1:0]      r_dispValid;
    logic [UOP:0]    r_dispUop0, r_dispUop1;
    logic [RS:0]     r_dispStn0, r_dispStn1;
    logic [TW-1:0]   r_dispRob0, r_dispRob1;

    logic            w_ready, w_enq, w_disp0, w_disp1, w_commit;
    logic [AW-1:0]   w_head1;
    logic [RS:0]     w_st0, w_st1;
    logic [1:0]      w_ndisp;
    logic [TW-1:0]   w_robHeadNext;
    logic [UW-1:0]   w_robUsedNext;

    assign w_ready  = (r_count < DEPTH_C);
    assign w_enq    = bus.inValid & w_ready & ~bus.flush;
    assign w_head1  = r_head + AW'(1);
    assign w_st0    = r_stn[r_head];
    assign w_st1    = r_stn[w_head1];

    // Slot 1 only ever rides along with slot 0, keeping dispatch strictly in order.
    assign w_disp0  = (r_count != '0) & ~bus.rsFull[w_st0] & (r_robUsed < ROB_N_C);
    assign w_disp1  = w_disp0 & (r_count >= CW'(2)) & (w_st1 != w_st0)
                    & ~bus.rsFull[w_st1] & (r_robUsed <= ROB_N2_C);
    assign w_ndisp  = {1'b0, w_disp0} + {1'b0, w_disp1};

    // A commit against an empty ROB is ignored rather than underflowing.
    assign w_commit      = bus.commitValid & (r_robUsed != '0);
    assign w_robHeadNext = r_robHead + TW'(w_commit);
    assign w_robUsedNext = r_robUsed + UW'(w_ndisp) - UW'(w_commit);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_uop[r_tail] <= bus.inUop;
            r_stn[r_tail] <= bus.inStation;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_robTail   <= '0;
            r_robHead   <= '0;
            r_robUsed   <= '0;
            r_robFree   <= ROB_N_C;
            r_dispValid <= '0;
            r_dispUop0  <= '0;
            r_dispUop1  <= '0;
            r_dispStn0  <= '0;
            r_dispStn1  <= '0;
            r_dispRob0  <= '0;
            r_dispRob1  <= '0;
        end else begin
            r_robHead <= w_robHeadNext;
            if (bus.flush) begin
                // Tag allocation resumes right behind whatever the ROB still holds after this commit.
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
                r_robUsed   <= '0;
                r_robFree   <= ROB_N_C;
                r_robTail   <= w_robHeadNext;
                r_dispValid <= '0;
            end else begin
                if (w_enq) r_tail <= r_tail + AW'(1);
                r_head      <= r_head + AW'(w_ndisp);
                r_count     <= r_count + CW'(w_enq) - CW'(w_ndisp);
                r_robUsed   <= w_robUsedNext;
                r_robFree   <= ROB_N_C - w_robUsedNext;
                r_robTail   <= r_robTail + TW'(w_ndisp);
                r_dispValid <= {w_disp1, w_disp0};
                if (w_disp0) begin
                    r_dispUop0 <= r_uop[r_head];
                    r_dispStn0 <= w_st0;
                    r_dispRob0 <= r_robTail;
                end
                if (w_disp1) begin
                    r_dispUop1 <= r_uop[w_head1];
                    r_dispStn1 <= w_st1;
                    r_dispRob1 <= r_robTail + TW'(1);
                end
            end
        end
    end

    assign bus.inReady      = w_ready;
    assign bus.freeze       = ~w_ready;
    assign bus.dispValid    = r_dispValid;
    assign bus.dispUop0     = r_dispUop0;
    assign bus.dispUop1     = r_dispUop1;
    assign bus.dispStation0 = r_dispStn0;
    assign bus.dispStation1 = r_dispStn1;
    assign bus.dispRob0     = r_dispRob0;
    assign bus.dispRob1     = r_dispRob1;
    assign bus.robFreeCount = r_robFree;
endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: queue-level reference model checked every cycle,
// plus hand-computed pins on the notable edges of each directed scenario.
module tb_dispatch_queue;
    localparam int UOP   = 95;
    localparam int DEPTH = 4;
    localparam int RS    = 1;
    localparam int ROB   = 2;
    localparam int ROB_N = 8;
    localparam int PW    = UOP + 1;

    logic clk;
    logic reset_n;
    bit   run;
    int   n_vec, n_err;

    dispatch_queue_if #(.UOP(UOP), .RS(RS), .ROB(ROB)) bus ();

    dispatch_queue #(.UOP(UOP), .DEPTH(DEPTH), .RS(RS), .ROB(ROB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [UOP:0] uop;
        logic [RS:0]  st;
    } ent_t;

    ent_t         q[$];
    int           m_used, m_tail, m_head, m_n, m_c;
    bit           m_acc;
    logic [1:0]   m_valid;
    logic [UOP:0] m_uop0, m_uop1;
    logic [RS:0]  m_st0, m_st1;
    int           m_rob0, m_rob1, m_free;

    // Reference model: a plain FIFO of micro-ops plus ROB occupancy arithmetic.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_used = 0; m_tail = 0; m_head = 0;
            m_valid = 2'b00; m_uop0 = '0; m_uop1 = '0; m_st0 = '0; m_st1 = '0;
            m_rob0 = 0; m_rob1 = 0; m_free = ROB_N;
        end else begin
            m_c   = (bus.commitValid && m_used > 0) ? 1 : 0;
            m_acc = bus.inValid && (q.size() < DEPTH);
            if (bus.flush) begin
                m_head  = (m_head + m_c) % ROB_N;
                q.delete();
                m_used  = 0;
                m_tail  = m_head;
                m_valid = 2'b00;
                m_free  = ROB_N;
            end else begin
                m_n = 0;
                if (q.size() >= 1 && !bus.rsFull[q[0].st] && m_used < ROB_N) begin
                    m_n = 1; m_uop0 = q[0].uop; m_st0 = q[0].st; m_rob0 = m_tail;
                end
                if (m_n == 1 && q.size() >= 2 && q[1].st != q[0].st &&
                    !bus.rsFull[q[1].st] && m_used <= ROB_N - 2) begin
                    m_n = 2; m_uop1 = q[1].uop; m_st1 = q[1].st; m_rob1 = (m_tail + 1) % ROB_N;
                end
                m_valid = (m_n == 2) ? 2'b11 : (m_n == 1) ? 2'b01 : 2'b00;
                for (int k = 0; k < m_n; k++) void'(q.pop_front());
                if (m_acc) q.push_back('{uop: bus.inUop, st: bus.inStation});
                m_used = m_used + m_n - m_c;
                m_tail = (m_tail + m_n) % ROB_N;
                m_head = (m_head + m_c) % ROB_N;
                m_free = ROB_N - m_used;
            end
        end
    end

    int pin_seq, last_seq;
    int p_vld, p_st0, p_uop0, p_rob0, p_rob1, p_free, p_rdy;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        #2;
        if (run) begin
            chk("dispValid", bus.dispValid, m_valid);
            chk("dispUop0", bus.dispUop0, m_uop0);
            chk("dispUop1", bus.dispUop1, m_uop1);
            chk("dispStation0", bus.dispStation0, m_st0);
            chk("dispStation1", bus.dispStation1, m_st1);
            chk("dispRob0", bus.dispRob0, m_rob0);
            chk("dispRob1", bus.dispRob1, m_rob1);
            chk("robFreeCount", bus.robFreeCount, m_free);
            chk("inReady", bus.inReady, q.size() < DEPTH);
            chk("freeze", bus.freeze, q.size() >= DEPTH);
            if (pin_seq != last_seq) begin
                last_seq = pin_seq;
                if (p_vld  >= 0) chk("pin_dispValid", bus.dispValid, p_vld);
                if (p_st0  >= 0) chk("pin_dispStation0", bus.dispStation0, p_st0);
                if (p_uop0 >= 0) chk("pin_dispUop0", bus.dispUop0, p_uop0);
                if (p_rob0 >= 0) chk("pin_dispRob0", bus.dispRob0, p_rob0);
                if (p_rob1 >= 0) chk("pin_dispRob1", bus.dispRob1, p_rob1);
                if (p_free >= 0) chk("pin_robFreeCount", bus.robFreeCount, p_free);
                if (p_rdy  >= 0) chk("pin_inReady", bus.inReady, p_rdy);
            end
        end
    end

    // Hand-computed expectation for the outputs after the next edge; -1 = don't care.
    task automatic pin(input int vld, input int st0, input int uop0, input int rob0,
                       input int rob1, input int free, input int rdy);
        p_vld = vld; p_st0 = st0; p_uop0 = uop0; p_rob0 = rob0;
        p_rob1 = rob1; p_free = free; p_rdy = rdy;
        pin_seq++;
    endtask

    task automatic drv(input bit v, input int u, input int s, input int f,
                       input bit cm, input bit fl);
        bus.inValid     = v;
        bus.inUop       = PW'(u);
        bus.inStation   = 2'(s);
        bus.rsFull      = 4'(f);
        bus.commitValid = cm;
        bus.flush       = fl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        pin(0, 0, 0, 0, 0, ROB_N, 1);
        bus.inValid = 1'b0; bus.inUop = '0; bus.inStation = '0;
        bus.rsFull = '0; bus.commitValid = 1'b0; bus.flush = 1'b0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0; pin_seq = 0; last_seq = 0; run = 1'b0;
        reset_n = 1'b1;
        bus.inValid = 1'b0; bus.inUop = '0; bus.inStation = '0;
        bus.rsFull = '0; bus.commitValid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        run = 1'b1;

        // Single micro-op: one-cycle enqueue-to-dispatch latency, tag 0.
        do_reset();
        pin(0, -1, -1, -1, -1, 8, 1);        drv(1, 'hA5, 2, 0, 0, 0);
        pin(1, 2, 'hA5, 0, -1, 7, 1);        drv(0, 0, 0, 0, 0, 0);
        pin(0, -1, -1, -1, -1, 8, 1);        drv(0, 0, 0, 0, 1, 0);

        // Fill to full with stations blocked, then drain two per cycle.
        do_reset();
        for (int i = 0; i < 3; i++) drv(1, 'h10 + i, i, 'hF, 0, 0);
        pin(0, -1, -1, -1, -1, 8, 0);        drv(1, 'h13, 3, 'hF, 0, 0);
        pin(0, -1, -1, -1, -1, 8, 0);        drv(1, 'h14, 0, 'hF, 0, 0);
        pin(3, 0, 'h10, 0, 1, 6, 1);         drv(1, 'h14, 0, 0, 0, 0);
        pin(3, 2, 'h12, 2, 3, 4, 1);         drv(1, 'h14, 0, 0, 0, 0);
        pin(1, 0, 'h14, 4, -1, 3, 1);        drv(0, 0, 0, 0, 0, 0);

        // Same-station pair and a blocked head: slot 1 never goes alone.
        do_reset();
        drv(1, 'h20, 0, 'h1, 0, 0);
        drv(1, 'h21, 0, 'h1, 0, 0);
        pin(1, 0, 'h20, 0, -1, 7, 1);        drv(0, 0, 0, 0, 0, 0);
        pin(1, 0, 'h21, 1, -1, 6, 1);        drv(0, 0, 0, 0, 0, 0);
        drv(1, 'h22, 0, 'h1, 0, 0);
        drv(1, 'h23, 1, 'h1, 0, 0);
        pin(0, -1, -1, -1, -1, 6, 1);        drv(0, 0, 0, 'h1, 0, 0);
        pin(1, 0, 'h22, 2, -1, 5, 1);        drv(0, 0, 0, 'h2, 0, 0);
        pin(1, 1, 'h23, 3, -1, 4, 1);        drv(0, 0, 0, 0, 0, 0);

        // ROB nearly full: one slot left, then wrap to tag 0 after a commit.
        do_reset();
        for (int i = 0; i < 7; i++) drv(1, 'h30 + i, i % 2, 0, 0, 0);
        pin(1, 0, 'h36, 6, -1, 1, 1);        drv(0, 0, 0, 0, 0, 0);
        drv(1, 'h40, 0, 'hF, 0, 0);
        pin(0, -1, -1, -1, -1, 1, 1);        drv(1, 'h41, 1, 'hF, 0, 0);
        pin(1, 0, 'h40, 7, -1, 0, 1);        drv(0, 0, 0, 0, 0, 0);
        pin(0, -1, -1, -1, -1, 1, 1);        drv(0, 0, 0, 0, 1, 0);
        pin(1, 1, 'h41, 0, -1, 0, 1);        drv(0, 0, 0, 0, 0, 0);

        // Flush with three queued and a commit at robHead=3: tags resume at 4.
        do_reset();
        for (int i = 0; i < 4; i++) drv(1, 'h50 + i, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 1, 0);
        pin(0, -1, -1, -1, -1, 7, 1);        drv(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) drv(1, 'h54 + i, i, 'hF, 0, 0);
        pin(0, -1, -1, -1, -1, 7, 1);        drv(1, 'h56, 2, 'hF, 0, 0);
        pin(0, -1, -1, -1, -1, 8, 1);        drv(1, 'h5E, 3, 'hF, 1, 1);
        pin(0, -1, -1, -1, -1, 8, 1);        drv(0, 0, 0, 0, 0, 0);
        pin(0, -1, -1, -1, -1, 8, 1);        drv(1, 'h5F, 1, 0, 0, 0);
        pin(1, 1, 'h5F, 4, -1, 7, 1);        drv(0, 0, 0, 0, 0, 0);

        // Asynchronous reset while a dual dispatch is on the outputs.
        do_reset();
        for (int i = 0; i < 4; i++) drv(1, 'h60 + i, i, 'hF, 0, 0);
        pin(3, 0, 'h60, 0, 1, 6, 1);         drv(0, 0, 0, 0, 0, 0);
        do_reset();
        pin(0, -1, -1, -1, -1, 8, 1);        drv(1, 'h70, 2, 0, 0, 0);
        pin(1, 2, 'h70, 0, -1, 7, 1);        drv(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
